// File: rtl/exc_ctrl_if.sv
// CPU-side CP0 access bundle: MTC0 request/grant handshake plus the CP0 write port.
interface exc_ctrl_if;
  logic        mtc0_req;
  logic [4:0]  mtc0_sel;
  logic [31:0] mtc0_data;
  logic        mtc0_ack;
  logic        cp0_wen;
  logic [4:0]  cp0_sel;
  logic [31:0] cp0_din;
  logic [31:0] cp0_pc;

  modport master (
    output mtc0_req, mtc0_sel, mtc0_data,
    input  mtc0_ack, cp0_wen, cp0_sel, cp0_din, cp0_pc
  );

  modport slave (
    input  mtc0_req, mtc0_sel, mtc0_data,
    output mtc0_ack, cp0_wen, cp0_sel, cp0_din, cp0_pc
  );
endinterface

// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer: saves EPC, enters the handler, services ERET,
// and arbitrates CPU MTC0 writes onto the CP0 write port.
module exc_ctrl #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter int          CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             int_req,
  input  logic             inst_done,
  input  logic             eret,
  input  logic [31:0]      next_pc,
  input  logic [31:0]      epc,
  exc_ctrl_if.slave        bus,
  output logic             exl_set,
  output logic             exl_clr,
  output logic             pc_redirect,
  output logic [31:0]      pc_target,
  output logic             stall,
  output logic [CNT_W-1:0] int_count
);

  typedef enum logic [1:0] {IDLE, SAVE, ENTER, RETURN} state_t;

  state_t      state, state_nxt;
  logic [31:0] saved_pc;
  logic        go_ret, go_int, grant;

  // rst gates only the IDLE-cycle outputs; next-state decode stays reset-free
  // so the async reset never enters a flop data path.
  always_comb begin
    state_nxt     = state;
    go_ret        = 1'b0;
    go_int        = 1'b0;
    grant         = 1'b0;
    exl_set       = 1'b0;
    exl_clr       = 1'b0;
    pc_redirect   = 1'b0;
    pc_target     = '0;
    stall         = 1'b0;
    bus.mtc0_ack  = 1'b0;
    bus.cp0_wen   = 1'b0;
    bus.cp0_sel   = '0;
    bus.cp0_din   = '0;
    bus.cp0_pc    = saved_pc;
    unique case (state)
      IDLE: begin
        go_ret = inst_done & eret;
        go_int = inst_done & ~eret & int_req;
        grant  = rst & bus.mtc0_req & ~go_ret & ~go_int;
        stall  = rst & (go_ret | go_int);
        if (go_ret)      state_nxt = RETURN;
        else if (go_int) state_nxt = SAVE;
        if (grant) begin
          bus.mtc0_ack = 1'b1;
          bus.cp0_wen  = 1'b1;
          bus.cp0_sel  = bus.mtc0_sel;
          bus.cp0_din  = bus.mtc0_data;
        end
      end
      SAVE: begin
        stall       = 1'b1;
        bus.cp0_wen = 1'b1;
        bus.cp0_sel = 5'd14;
        bus.cp0_din = saved_pc;
        state_nxt   = ENTER;
      end
      ENTER: begin
        stall       = 1'b1;
        exl_set     = 1'b1;
        pc_redirect = 1'b1;
        pc_target   = HANDLER_ADDR;
        state_nxt   = IDLE;
      end
      RETURN: begin
        stall       = 1'b1;
        exl_clr     = 1'b1;
        pc_redirect = 1'b1;
        pc_target   = epc;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      saved_pc  <= '0;
      int_count <= '0;
    end else begin
      state <= state_nxt;
      if (go_int) saved_pc <= next_pc;
      if (state == ENTER && int_count != '1) int_count <= int_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// Bench for exc_ctrl: directed scenarios plus random traffic against a
// queue-based sequence model; a second instance runs with a 2-bit counter.
module tb_exc_ctrl;

  localparam logic [31:0] HANDLER = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        int_req = 1'b0, inst_done = 1'b0, eret = 1'b0;
  logic [31:0] next_pc = '0, epc = '0;
  logic        exl_set, exl_clr, pc_redirect, stall;
  logic [31:0] pc_target;
  logic [15:0] int_count;
  logic        exl_set2, exl_clr2, pc_redirect2, stall2;
  logic [31:0] pc_target2;
  logic [1:0]  int_count2;

  exc_ctrl_if bus ();
  exc_ctrl_if bus2 ();

  assign bus2.mtc0_req  = bus.mtc0_req;
  assign bus2.mtc0_sel  = bus.mtc0_sel;
  assign bus2.mtc0_data = bus.mtc0_data;

  exc_ctrl #(.HANDLER_ADDR(HANDLER), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .int_req(int_req), .inst_done(inst_done), .eret(eret),
    .next_pc(next_pc), .epc(epc), .bus(bus.slave), .exl_set(exl_set), .exl_clr(exl_clr),
    .pc_redirect(pc_redirect), .pc_target(pc_target), .stall(stall), .int_count(int_count)
  );

  exc_ctrl #(.HANDLER_ADDR(HANDLER), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .int_req(int_req), .inst_done(inst_done), .eret(eret),
    .next_pc(next_pc), .epc(epc), .bus(bus2.slave), .exl_set(exl_set2), .exl_clr(exl_clr2),
    .pc_redirect(pc_redirect2), .pc_target(pc_target2), .stall(stall2), .int_count(int_count2)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        mtc0_ack;
    logic        cp0_wen;
    logic [4:0]  cp0_sel;
    logic [31:0] cp0_din;
    logic [31:0] cp0_pc;
    logic        exl_set;
    logic        exl_clr;
    logic        pc_redirect;
    logic [31:0] pc_target;
    logic        stall;
    logic [15:0] int_count;
  } obs_t;

  // Reference model: a pending sequence is a queue of busy cycles.
  typedef enum {PH_SAVE, PH_ENTER, PH_RET} phase_e;
  phase_e      m_q[$];
  logic [31:0] m_saved_pc = '0;
  int unsigned m_cnt = 0;

  int checks = 0;
  int errors = 0;

  function automatic obs_t obs1();
    obs_t o;
    o.mtc0_ack = bus.mtc0_ack;  o.cp0_wen = bus.cp0_wen;  o.cp0_sel = bus.cp0_sel;
    o.cp0_din = bus.cp0_din;    o.cp0_pc = bus.cp0_pc;    o.exl_set = exl_set;
    o.exl_clr = exl_clr;        o.pc_redirect = pc_redirect;
    o.pc_target = pc_target;    o.stall = stall;          o.int_count = int_count;
    return o;
  endfunction

  function automatic obs_t obs2();
    obs_t o;
    o.mtc0_ack = bus2.mtc0_ack; o.cp0_wen = bus2.cp0_wen; o.cp0_sel = bus2.cp0_sel;
    o.cp0_din = bus2.cp0_din;   o.cp0_pc = bus2.cp0_pc;   o.exl_set = exl_set2;
    o.exl_clr = exl_clr2;       o.pc_redirect = pc_redirect2;
    o.pc_target = pc_target2;   o.stall = stall2;         o.int_count = {14'd0, int_count2};
    return o;
  endfunction

  function automatic obs_t model_expect(int unsigned cnt_max);
    obs_t e = '0;
    if (!rst) return e;
    e.cp0_pc    = m_saved_pc;
    e.int_count = 16'(m_cnt > cnt_max ? cnt_max : m_cnt);
    if (m_q.size() != 0) begin
      e.stall = 1'b1;
      case (m_q[0])
        PH_SAVE:  begin e.cp0_wen = 1'b1; e.cp0_sel = 5'd14; e.cp0_din = m_saved_pc; end
        PH_ENTER: begin e.exl_set = 1'b1; e.pc_redirect = 1'b1; e.pc_target = HANDLER; end
        default:  begin e.exl_clr = 1'b1; e.pc_redirect = 1'b1; e.pc_target = epc; end
      endcase
    end else if (inst_done && (eret || int_req)) begin
      e.stall = 1'b1;
    end else if (bus.mtc0_req) begin
      e.mtc0_ack = 1'b1; e.cp0_wen = 1'b1;
      e.cp0_sel = bus.mtc0_sel; e.cp0_din = bus.mtc0_data;
    end
    return e;
  endfunction

  function automatic void model_reset();
    m_q.delete();
    m_saved_pc = '0;
    m_cnt = 0;
  endfunction

  function automatic void model_advance();
    if (!rst) begin
      model_reset();
    end else if (m_q.size() != 0) begin
      if (m_q[0] == PH_ENTER && m_cnt < 32'hFFFF) m_cnt++;
      void'(m_q.pop_front());
    end else if (inst_done) begin
      if (eret) m_q.push_back(PH_RET);
      else if (int_req) begin
        m_saved_pc = next_pc;
        m_q.push_back(PH_SAVE);
        m_q.push_back(PH_ENTER);
      end
    end
  endfunction

  task automatic tick();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    int_req = 1'b0; inst_done = 1'b0; eret = 1'b0; bus.mtc0_req = 1'b0;
  endtask

  task automatic test_reset();
    obs_t got, exp;
    for (int i = 0; i < 4; i++) begin
      int_req = 1'b1; inst_done = 1'b1; eret = 1'($urandom_range(0, 1));
      bus.mtc0_req = 1'b1; bus.mtc0_sel = 5'($urandom); bus.mtc0_data = $urandom;
      next_pc = $urandom; epc = $urandom;
      #1;
      got = obs1(); exp = '0;
      checks++;
      if (got !== exp) begin errors++; $display("FAIL reset_outputs: got %h want %h", got, exp); end
      got = obs2();
      checks++;
      if (got !== exp) begin errors++; $display("FAIL reset_outputs_w2: got %h want %h", got, exp); end
      model_reset();
      @(posedge clk); #1;
    end
    idle_inputs();
    rst = 1'b1;
    #1;
  endtask

  task automatic test_interrupt();
    obs_t got, exp;
    int_req = 1'b1; inst_done = 1'b1; eret = 1'b0; next_pc = 32'h3010;
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL int_idle_stall: got %b want 1", stall); end
    tick();
    int_req = 1'b0; inst_done = 1'b0; next_pc = $urandom;
    #1;
    got = obs1(); exp = model_expect(32'hFFFF);
    checks++;
    if (got !== exp) begin errors++; $display("FAIL int_save: got %h want %h", got, exp); end
    checks++;
    if ({bus.cp0_wen, bus.cp0_sel, bus.cp0_din} !== {1'b1, 5'd14, 32'h3010}) begin
      errors++;
      $display("FAIL int_save_port: got %b/%0d/%h want 1/14/00003010", bus.cp0_wen, bus.cp0_sel, bus.cp0_din);
    end
    tick();
    got = obs1(); exp = model_expect(32'hFFFF);
    checks++;
    if (got !== exp) begin errors++; $display("FAIL int_enter: got %h want %h", got, exp); end
    checks++;
    if ({exl_set, pc_redirect, pc_target} !== {1'b1, 1'b1, 32'h4180}) begin
      errors++;
      $display("FAIL int_enter_redirect: got %b/%b/%h want 1/1/00004180", exl_set, pc_redirect, pc_target);
    end
    tick();
    checks++;
    if ({int_count, stall} !== {16'd1, 1'b0}) begin
      errors++; $display("FAIL int_count_after: got %0d stall %b want 1 stall 0", int_count, stall);
    end
  endtask

  task automatic test_eret();
    obs_t got, exp;
    inst_done = 1'b1; eret = 1'b1; int_req = 1'b0; epc = 32'h3010;
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL eret_idle_stall: got %b want 1", stall); end
    tick();
    inst_done = 1'b0; eret = 1'b0;
    #1;
    got = obs1(); exp = model_expect(32'hFFFF);
    checks++;
    if (got !== exp) begin errors++; $display("FAIL eret_return: got %h want %h", got, exp); end
    checks++;
    if ({exl_clr, exl_set, pc_redirect, pc_target, stall} !== {1'b1, 1'b0, 1'b1, 32'h3010, 1'b1}) begin
      errors++; $display("FAIL eret_return_fields: got clr %b set %b redir %b tgt %h stall %b want 1 0 1 00003010 1",
                         exl_clr, exl_set, pc_redirect, pc_target, stall);
    end
    tick();
    checks++;
    if ({stall, pc_redirect, pc_target} !== {1'b0, 1'b0, 32'h0}) begin
      errors++; $display("FAIL eret_done: got stall %b redir %b tgt %h want 0 0 0", stall, pc_redirect, pc_target);
    end
  endtask

  task automatic test_eret_priority();
    obs_t got, exp;
    inst_done = 1'b1; eret = 1'b1; int_req = 1'b1; epc = 32'h5000; next_pc = 32'h7777_0000;
    #1;
    tick();
    idle_inputs();
    #1;
    got = obs1(); exp = model_expect(32'hFFFF);
    checks++;
    if (got !== exp) begin errors++; $display("FAIL prio_return: got %h want %h", got, exp); end
    checks++;
    if ({exl_clr, bus.cp0_wen, pc_target} !== {1'b1, 1'b0, 32'h5000}) begin
      errors++; $display("FAIL prio_no_save: got clr %b wen %b tgt %h want 1 0 00005000", exl_clr, bus.cp0_wen, pc_target);
    end
    tick();
    tick();
    checks++;
    if ({int_count, bus.cp0_pc} !== {16'd1, 32'h3010}) begin
      errors++; $display("FAIL prio_count: got %0d pc %h want 1 00003010", int_count, bus.cp0_pc);
    end
  endtask

  task automatic test_mtc0_blocked();
    obs_t got, exp;
    int_req = 1'b1; inst_done = 1'b1; next_pc = 32'h0000_2000;
    bus.mtc0_req = 1'b1; bus.mtc0_sel = 5'd12; bus.mtc0_data = 32'h0000_FC01;
    #1;
    for (int c = 0; c < 3; c++) begin
      got = obs1(); exp = model_expect(32'hFFFF);
      checks++;
      if (got !== exp || bus.mtc0_ack !== 1'b0) begin
        errors++; $display("FAIL mtc0_held c%0d: got %h want %h", c, got, exp);
      end
      tick();
      int_req = 1'b0; inst_done = 1'b0;
      #1;
    end
    checks++;
    if ({bus.mtc0_ack, bus.cp0_wen, bus.cp0_sel, bus.cp0_din} !== {1'b1, 1'b1, 5'd12, 32'h0000_FC01}) begin
      errors++; $display("FAIL mtc0_grant: got %b %b %0d %h want 1 1 12 0000fc01",
                         bus.mtc0_ack, bus.cp0_wen, bus.cp0_sel, bus.cp0_din);
    end
    bus.mtc0_sel = 5'd13; bus.mtc0_data = 32'hDEAD_0013;
    #1;
    checks++;
    if ({bus.mtc0_ack, bus.cp0_sel, bus.cp0_din} !== {1'b1, 5'd13, 32'hDEAD_0013}) begin
      errors++; $display("FAIL mtc0_sel13: got %b %0d %h want 1 13 dead0013", bus.mtc0_ack, bus.cp0_sel, bus.cp0_din);
    end
    tick();
    idle_inputs();
    #1;
  endtask

  task automatic test_reset_mid();
    obs_t got, exp;
    int_req = 1'b1; inst_done = 1'b1; next_pc = 32'h0000_9ABC;
    #1;
    tick();
    idle_inputs();
    #1;
    rst = 1'b0;
    #1;
    model_reset();
    got = obs1(); exp = '0;
    checks++;
    if (got !== exp) begin errors++; $display("FAIL midrst_outputs: got %h want %h", got, exp); end
    tick();
    rst = 1'b1;
    #1;
    for (int c = 0; c < 3; c++) begin
      got = obs1(); exp = model_expect(32'hFFFF);
      checks++;
      if (got !== exp || exl_set !== 1'b0 || int_count !== 16'd0) begin
        errors++; $display("FAIL midrst_after c%0d: got %h want %h", c, got, exp);
      end
      tick();
    end
  endtask

  task automatic test_saturate();
    obs_t got, exp;
    for (int n = 0; n < 4; n++) begin
      int_req = 1'b1; inst_done = 1'b1; next_pc = 32'(n * 4 + 32'h100);
      #1;
      tick();
      idle_inputs();
      tick();
      tick();
    end
    got = obs2(); exp = model_expect(3);
    checks++;
    if (got !== exp) begin errors++; $display("FAIL sat_w2_state: got %h want %h", got, exp); end
    checks++;
    if ({int_count2, int_count} !== {2'd3, 16'd4}) begin
      errors++; $display("FAIL sat_counts: got w2 %0d w16 %0d want 3 4", int_count2, int_count);
    end
  endtask

  task automatic test_random();
    obs_t got, exp;
    for (int c = 0; c < 400; c++) begin
      int_req      = ($urandom_range(0, 99) < 30);
      inst_done    = ($urandom_range(0, 99) < 50);
      eret         = ($urandom_range(0, 99) < 15);
      next_pc      = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      epc          = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      bus.mtc0_req = ($urandom_range(0, 99) < 30);
      bus.mtc0_sel = 5'($urandom);
      bus.mtc0_data = $urandom;
      #1;
      got = obs1(); exp = model_expect(32'hFFFF);
      checks++;
      if (got !== exp) begin errors++; $display("FAIL rand_w16 c%0d: got %h want %h", c, got, exp); end
      got = obs2(); exp = model_expect(3);
      checks++;
      if (got !== exp) begin errors++; $display("FAIL rand_w2 c%0d: got %h want %h", c, got, exp); end
      checks++;
      if (exl_set && exl_clr) begin errors++; $display("FAIL rand_exl_both c%0d: got 1/1 want not both", c); end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    bus.mtc0_req = 1'b0; bus.mtc0_sel = '0; bus.mtc0_data = '0;
    @(posedge clk); #1;
    test_reset();
    test_interrupt();
    test_eret();
    test_eret_priority();
    test_mtc0_blocked();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/exc_ctrl.md
EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 Parameter HANDLER_ADDR, default 32'h0000_4180, interrupt handler entry address.
REQ-002 Parameter CNT_W, default 16, width of taken-interrupt counter.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 int_req  in  1  CP0 interrupt request (IntReq).
REQ-006 inst_done  in  1  current instruction retires this cycle (instruction boundary).
REQ-007 eret  in  1  retiring instruction is ERET; qualified by inst_done.
REQ-008 next_pc  in  32  PC of the next instruction; qualified by inst_done.
REQ-009 epc  in  32  CP0 EPC output.
REQ-010 mtc0_req / mtc0_sel / mtc0_data  in  1/5/32  CPU request to write CP0 register.
REQ-011 mtc0_ack  out  1  mtc0 write performed this cycle.
REQ-012 cp0_wen / cp0_sel / cp0_din / cp0_pc  out  1/5/32/32  CP0 write port (Wen, Sel, CPIn, PC).
REQ-013 exl_set / exl_clr  out  1/1  CP0 EXLSet / EXLClr strobes.
REQ-014 pc_redirect / pc_target  out  1/32  PC override strobe and address.
REQ-015 stall  out  1  holds CPU fetch/retire while controller is not IDLE.
REQ-016 int_count  out  CNT_W  number of interrupts taken, saturating.

Function
REQ-017 FSM states IDLE, SAVE, ENTER, RETURN; encoding free; one state per cycle.
REQ-018 IDLE, inst_done=1, eret=1 -> RETURN (eret wins over a simultaneous int_req).
REQ-019 IDLE, inst_done=1, eret=0, int_req=1 -> SAVE; saved_pc register <= next_pc.
REQ-020 IDLE otherwise -> IDLE; int_req without inst_done is never taken.
REQ-021 SAVE: cp0_wen=1, cp0_sel=14, cp0_din=saved_pc, cp0_pc=saved_pc; next state ENTER.
REQ-022 ENTER: exl_set=1, pc_redirect=1, pc_target=HANDLER_ADDR; int_count increments unless all-ones; next IDLE.
REQ-023 RETURN: exl_clr=1, pc_redirect=1, pc_target=epc (sampled this cycle); next IDLE.
REQ-024 stall=1 in SAVE, ENTER, RETURN, and in the IDLE cycle that transitions to SAVE or RETURN; else 0.
REQ-025 mtc0 in IDLE with no transition this cycle: cp0_wen=1, cp0_sel=mtc0_sel, cp0_din=mtc0_data, mtc0_ack=1, same cycle (combinational grant).
REQ-026 mtc0 in any other cycle: mtc0_ack=0, no CP0 write; requester holds request until acked (interrupt sequencing has priority).
REQ-027 mtc0_sel of 13 or 15 is still acked and forwarded; CP0 ignores it.
REQ-028 exl_set and exl_clr never both 1; each asserted exactly one cycle per sequence.
REQ-029 All outputs not listed for a state are 0, except cp0_pc=saved_pc at all times.
REQ-030 pc_redirect is a single-cycle pulse; pc_target=0 when pc_redirect=0.
REQ-031 inst_done/eret/int_req ignored outside IDLE (CPU is stalled).

Reset
REQ-032 rst=0 asynchronously forces IDLE, saved_pc=0, int_count=0; all outputs 0 while rst=0.
REQ-033 Reset mid-sequence (SAVE/ENTER/RETURN) aborts with no further strobes; after release controller is IDLE.
REQ-034 First transition possible on the first rising edge after rst deasserts.

Verification
REQ-035 int_req=1, inst_done=1, next_pc=0x3010 -> cycle+1 SAVE: cp0_wen=1, sel=14, din=0x3010; cycle+2 exl_set=1, pc_redirect=1, target=0x4180; int_count=1.
REQ-036 IDLE, inst_done=1, eret=1, epc=0x3010 -> next cycle exl_clr=1, pc_redirect=1, target=0x3010; stall high 2 cycles.
REQ-037 eret=1 and int_req=1 with inst_done=1 -> RETURN taken, no SAVE, int_count unchanged.
REQ-038 mtc0_req=1 sel=12 data=0x0000_FC01 in the cycle an interrupt is taken -> ack=0 for 3 cycles, ack=1 with cp0_sel=12, din=0x0000_FC01 on first IDLE cycle.
REQ-039 rst pulsed low during SAVE -> outputs 0 immediately, no exl_set afterwards, int_count=0.
REQ-040 CNT_W=2, four interrupts taken -> int_count holds 3.
